// File: rtl/lsu_if.sv
// Core-side request/response and memory-side port bundle of the load/store unit.
// slave is the LSU view; master is the pipeline/memory environment view.
interface lsu_if #(
  parameter int XLEN = 32
) ();
  logic              req_valid;
  logic              req_write;
  logic [2:0]        req_size;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_fault;
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
    output stall, rsp_valid, rsp_rdata, rsp_fault, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, mem_ack, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, rsp_fault, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: aligns stores, extends loads, flags misaligned/illegal/timeout; >=3 cycles per access.
// Stalls the pipeline while an access is pending; memory side holds mem_* stable until mem_ack.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, stateNext;

  logic [XLEN-1:0] addrQ, wdataQ, rdataQ;
  logic [NB-1:0]   strbQ;
  logic            weQ, faultQ;
  logic [2:0]      sizeQ;
  logic [OFFW-1:0] offQ;
  logic [CW-1:0]   cnt;

  logic            sizeOk, alignOk, legal, timeoutHit;
  logic [OFFW-1:0] off;
  logic [7:0]      laneMask;
  logic [NB-1:0]   laneMaskN, strbNext;
  logic [XLEN-1:0] dataMask, wdataNext, shifted, loadData;

  // Size codes 011/110 only exist on a 64-bit datapath; 1xx are load-only.
  always_comb begin
    sizeOk = 1'b0;
    case (bus.req_size)
      3'b000, 3'b001, 3'b010: sizeOk = 1'b1;
      3'b011:                 sizeOk = (XLEN == 64);
      3'b100, 3'b101:         sizeOk = !bus.req_write;
      3'b110:                 sizeOk = !bus.req_write && (XLEN == 64);
      default:                sizeOk = 1'b0;
    endcase
  end

  always_comb begin
    alignOk  = 1'b1;
    laneMask = 8'h01;
    case (bus.req_size[1:0])
      2'd0: begin alignOk = 1'b1;                      laneMask = 8'h01; end
      2'd1: begin alignOk = !bus.req_addr[0];          laneMask = 8'h03; end
      2'd2: begin alignOk = bus.req_addr[1:0] == 2'b0; laneMask = 8'h0F; end
      default: begin alignOk = bus.req_addr[2:0] == 3'b0; laneMask = 8'hFF; end
    endcase
  end

  assign legal = sizeOk && alignOk;
  assign off   = bus.req_addr[OFFW-1:0];

  always_comb begin
    laneMaskN = NB'(laneMask);
    dataMask  = '0;
    for (int i = 0; i < NB; i++) begin
      dataMask[8*i +: 8] = {8{laneMaskN[i]}};
    end
    strbNext  = laneMaskN << off;
    wdataNext = (bus.req_wdata & dataMask) << {off, 3'b000};
  end

  // Size-cast of a signed slice gives sign extension to XLEN.
  assign shifted = bus.mem_rdata >> {offQ, 3'b000};
  always_comb begin
    loadData = '0;
    case (sizeQ)
      3'b000:  loadData = XLEN'($signed(shifted[7:0]));
      3'b001:  loadData = XLEN'($signed(shifted[15:0]));
      3'b010:  loadData = XLEN'($signed(shifted[31:0]));
      3'b011:  loadData = shifted;
      3'b100:  loadData = XLEN'(shifted[7:0]);
      3'b101:  loadData = XLEN'(shifted[15:0]);
      3'b110:  loadData = XLEN'(shifted[31:0]);
      default: loadData = '0;
    endcase
  end

  assign timeoutHit = (TIMEOUT != 0) && (cnt == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    bus.mem_req   = 1'b0;
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.stall = bus.req_valid;
        if (bus.req_valid) stateNext = legal ? BUSY : RESP;
      end
      BUSY: begin
        bus.mem_req = 1'b1;
        bus.stall   = bus.req_valid;
        if (bus.mem_ack || timeoutHit) stateNext = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // cnt holds the 1-based index of the current BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ  <= '0;
      strbQ  <= '0;
      wdataQ <= '0;
      weQ    <= 1'b0;
      sizeQ  <= '0;
      offQ   <= '0;
      cnt    <= '0;
      rdataQ <= '0;
      faultQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (legal) begin
              addrQ  <= {bus.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              strbQ  <= bus.req_write ? strbNext : '0;
              wdataQ <= wdataNext;
              weQ    <= bus.req_write;
              sizeQ  <= bus.req_size;
              offQ   <= off;
              cnt    <= CW'(1);
            end else begin
              faultQ <= 1'b1;
              rdataQ <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            rdataQ <= weQ ? '0 : loadData;
            faultQ <= 1'b0;
            cnt    <= '0;
          end else if (timeoutHit) begin
            rdataQ <= '0;
            faultQ <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = (state == BUSY) && weQ;
  assign bus.mem_addr  = addrQ;
  assign bus.mem_wstrb = strbQ;
  assign bus.mem_wdata = wdataQ;
  assign bus.rsp_rdata = rdataQ;
  assign bus.rsp_fault = (state == RESP) && faultQ;
endmodule
